// File: rtl/load_register.sv
// Enable-load register with asynchronous active-high clear, used to capture DMA request fields.
// Optional REG_VALID_EN macro adds a sticky data_valid flop that marks a load since reset.
module load_register #(
    parameter int          REG_DEPTH   = 8,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_en,
    input  logic [REG_DEPTH-1:0] data_in,
`ifdef REG_VALID_EN
    output logic                 data_valid,
`endif
    output logic [REG_DEPTH-1:0] data_out
);

    localparam logic [REG_DEPTH-1:0] RST_VAL = RESET_VALUE[REG_DEPTH-1:0];

    logic [REG_DEPTH-1:0] data_q;

    // rst wins over reg_en; data_in is only sampled on enabled edges, so X on it while idle is harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_q <= RST_VAL;
        else if (reg_en)
            data_q <= data_in;
    end

    assign data_out = data_q;

`ifdef REG_VALID_EN
    logic valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= 1'b0;
        else if (reg_en)
            valid_q <= 1'b1;
    end

    assign data_valid = valid_q;
`endif

endmodule

// File: tb/tb_load_register.sv
// Directed bench for load_register: two 6-bit instances (reset values 0 and 6'h11) sharing
// stimulus, plus a 1-bit instance.
module tb_load_register;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    logic       rst_a, en_a;
    logic [5:0] din_a, dout_a, dout_b;
    logic       rst_c, en_c, din_c, dout_c;
`ifdef REG_VALID_EN
    logic       dv_a, dv_b, dv_c;
`endif

    int total = 0;
    int bad   = 0;

    load_register #(.REG_DEPTH(6), .RESET_VALUE(64'd0)) dut_a (
        .clk(clk), .rst(rst_a), .reg_en(en_a), .data_in(din_a),
`ifdef REG_VALID_EN
        .data_valid(dv_a),
`endif
        .data_out(dout_a)
    );

    load_register #(.REG_DEPTH(6), .RESET_VALUE(64'h11)) dut_b (
        .clk(clk), .rst(rst_a), .reg_en(en_a), .data_in(din_a),
`ifdef REG_VALID_EN
        .data_valid(dv_b),
`endif
        .data_out(dout_b)
    );

    load_register #(.REG_DEPTH(1), .RESET_VALUE(64'd0)) dut_c (
        .clk(clk), .rst(rst_c), .reg_en(en_c), .data_in(din_c),
`ifdef REG_VALID_EN
        .data_valid(dv_c),
`endif
        .data_out(dout_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] hold_pat [3];
        hold_pat[0] = 6'h3F;
        hold_pat[1] = 6'h00;
        hold_pat[2] = 6'bxxxxxx;

        // reset with the clock stopped
        rst_a = 1'b1; en_a = 1'b0; din_a = 6'h00;
        rst_c = 1'b1; en_c = 1'b0; din_c = 1'b0;
        #2;
        check("rst_a", 64'(dout_a), 64'h00);
        check("rst_b", 64'(dout_b), 64'h11);
        check("rst_c", 64'(dout_c), 64'h0);
`ifdef REG_VALID_EN
        check("rst_dv_a", 64'(dv_a), 64'h0);
`endif

        rst_a = 1'b0; rst_c = 1'b0;
        clk_run = 1'b1;

        // single load of 6'h15
        @(negedge clk);
        en_a = 1'b1; din_a = 6'h15;
        edge_sample();
        check("load_a", 64'(dout_a), 64'h15);
        check("load_b", 64'(dout_b), 64'h15);
`ifdef REG_VALID_EN
        check("load_dv_a", 64'(dv_a), 64'h1);
`endif

        // hold for 10 cycles with data_in wandering, including X
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en_a = 1'b0; din_a = hold_pat[i % 3];
            edge_sample();
            check($sformatf("hold_a_%0d", i), 64'(dout_a), 64'h15);
        end
        check("hold_b", 64'(dout_b), 64'h15);

        // rst and reg_en together: reset wins
        @(negedge clk);
        en_a = 1'b1; din_a = 6'h2A; rst_a = 1'b1;
        edge_sample();
        check("both_a", 64'(dout_a), 64'h00);
        check("both_b", 64'(dout_b), 64'h11);
`ifdef REG_VALID_EN
        check("both_dv_a", 64'(dv_a), 64'h0);
`endif

        // reload 6'h2A, then a 2 ns rst pulse between edges
        @(negedge clk);
        rst_a = 1'b0; en_a = 1'b1; din_a = 6'h2A;
        edge_sample();
        check("reload_a", 64'(dout_a), 64'h2A);
        check("reload_b", 64'(dout_b), 64'h2A);
        @(negedge clk);
        en_a = 1'b0;
        #1; rst_a = 1'b1;
        #1;
        check("pulse_a", 64'(dout_a), 64'h00);
        check("pulse_b", 64'(dout_b), 64'h11);
        #1; rst_a = 1'b0;
        edge_sample();
        check("post_pulse_a", 64'(dout_a), 64'h00);
        check("post_pulse_b", 64'(dout_b), 64'h11);
`ifdef REG_VALID_EN
        check("post_pulse_dv_b", 64'(dv_b), 64'h0);
`endif

        // 1-bit instance: load 1, hold 5, load 0
        @(negedge clk);
        en_c = 1'b1; din_c = 1'b1;
        edge_sample();
        check("c_load1", 64'(dout_c), 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en_c = 1'b0; din_c = i[0];
            edge_sample();
            check($sformatf("c_hold_%0d", i), 64'(dout_c), 64'h1);
        end
        @(negedge clk);
        en_c = 1'b1; din_c = 1'b0;
        edge_sample();
        check("c_load0", 64'(dout_c), 64'h0);
`ifdef REG_VALID_EN
        check("c_dv", 64'(dv_c), 64'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
